fir_sym_mc: RTL and testbench

- Parametrised, multi-channel, time-interleaved symmetric FIR filter with runtime-loadable, double-buffered coefficients.
- Successor to the fixed 16-tap pipelined FIR. Adds:
  - per-channel delay lines;
  - a valid/ready handshake with backpressure;
  - full-precision internal arithmetic with round-half-up and saturation;
  - a saturation flag.
- Sits between the sample source and the downstream decimator/stream sink in the DSP datapath.

---
 rtl/fir_pkg.sv | 29 ++
 rtl/fir_adder_tree.sv | 47 ++++
 rtl/fir_sym_mc.sv | 95 +++++++++
 tb/tb_fir_sym_mc.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// fir_pkg: width helpers, latency and round/saturate arithmetic shared by the FIR blocks
package fir_pkg;
  function automatic int chw(input int n_ch);
    return n_ch > 1 ? $clog2(n_ch) : 1;
  endfunction
  function automatic int pw(input int dw);
    return dw + 1;
  endfunction
  function automatic int mw(input int dw, input int cw);
    return pw(dw) + cw;
  endfunction
  function automatic int aw(input int dw, input int cw, input int n_taps);
    return mw(dw, cw) + $clog2(n_taps / 2);
  endfunction
  function automatic int lat(input int n_taps);
    return 4 + $clog2(n_taps / 2);
  endfunction
  function automatic logic signed [63:0] rnd(input logic signed [63:0] s, input int frac);
    return (s + ((frac > 0) ? (64'sd1 <<< (frac - 1)) : 64'sd0)) >>> frac;
  endfunction
  function automatic logic signed [63:0] clip(input logic signed [63:0] r, input int dw);
    logic signed [63:0] hi;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    return r > hi ? hi : r < -hi - 64'sd1 ? -hi - 64'sd1 : r;
  endfunction
  function automatic logic clipped(input logic signed [63:0] r, input int dw);
    return clip(r, dw) != r;
  endfunction
endpackage

// File: rtl/fir_adder_tree.sv
// fir_adder_tree: pipelined pairwise signed adder tree with valid/channel tags
module fir_adder_tree #(
  parameter int N = 8, W = 37, CHW = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic d_valid,
  input  logic [CHW-1:0] d_ch,
  input  logic signed [W-1:0] d [N],
  output logic q_valid,
  output logic [CHW-1:0] q_ch,
  output logic signed [W+$clog2(N)-1:0] q
);
  localparam int L = $clog2(N), AW = W + L;
  for (genvar l = 0; l < L; l++) begin : g_l
    localparam int M = N >> (l + 1);
    logic signed [AW-1:0] a [2*M];
    logic signed [AW-1:0] s [M];
    logic av, v;
    logic [CHW-1:0] ac, c;
    if (l == 0) begin : g_in
      for (genvar i = 0; i < N; i++) begin : g_i
        assign a[i] = AW'(d[i]);
      end
      assign av = d_valid;
      assign ac = d_ch;
    end else begin : g_nx
      assign a = g_l[l-1].s;
      assign av = g_l[l-1].v;
      assign ac = g_l[l-1].c;
    end
    always_ff @(posedge clk or posedge reset)
      if (reset) begin
        for (int i = 0; i < M; i++) s[i] <= '0;
        v <= 1'b0;
        c <= '0;
      end else if (en) begin
        for (int i = 0; i < M; i++) s[i] <= a[2*i] + a[2*i+1];
        v <= av;
        c <= ac;
      end
  end
  assign q = g_l[L-1].s[0];
  assign q_valid = g_l[L-1].v;
  assign q_ch = g_l[L-1].c;
endmodule

// File: rtl/fir_sym_mc.sv
// fir_sym_mc: time-interleaved multi-channel symmetric FIR with double-buffered coefficients
module fir_sym_mc import fir_pkg::*; #(
  parameter int DW = 18, CW = 18, N_TAPS = 16, N_CH = 2, FRAC = 17
) (
  input  logic clk,
  input  logic reset,
  input  logic i_valid,
  output logic i_ready,
  input  logic signed [DW-1:0] i_data,
  input  logic [chw(N_CH)-1:0] i_ch,
  output logic o_valid,
  input  logic o_ready,
  output logic signed [DW-1:0] o_data,
  output logic [chw(N_CH)-1:0] o_ch,
  output logic o_sat,
  input  logic coef_we,
  input  logic [$clog2(N_TAPS/2)-1:0] coef_addr,
  input  logic signed [CW-1:0] coef_data,
  input  logic coef_swap
);
  localparam int NU = N_TAPS / 2, CHW = chw(N_CH), PW = pw(DW), MW = mw(DW, CW), AW = aw(DW, CW, N_TAPS);
  logic adv, take, ch_ok, s0_v, s1_v, s2_v, t_v;
  logic [CHW-1:0] s0_c, s1_c, s2_c, t_c;
  logic signed [DW-1:0] dl [N_CH][N_TAPS];
  logic signed [DW-1:0] s0 [N_TAPS];
  logic signed [PW-1:0] s1 [NU];
  logic signed [MW-1:0] s2 [NU];
  logic signed [CW-1:0] shadow [NU], active [NU];
  logic signed [AW-1:0] t_sum;
  logic signed [63:0] rr;
  assign adv = !o_valid | o_ready;
  assign i_ready = adv;
  if ((1 << CHW) > N_CH) begin : g_chk
    assign ch_ok = int'(i_ch) < N_CH;
  end else begin : g_all
    assign ch_ok = 1'b1;
  end
  assign take = i_valid & ch_ok;
  // out-of-range channels are consumed but leave a bubble behind
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      for (int c = 0; c < N_CH; c++)
        for (int k = 0; k < N_TAPS; k++) dl[c][k] <= '0;
      s0 <= '{default: '0};
      s1 <= '{default: '0};
      s2 <= '{default: '0};
      {s0_v, s1_v, s2_v} <= '0;
      {s0_c, s1_c, s2_c} <= '0;
    end else if (adv) begin
      s0_v <= take;
      s0_c <= i_ch;
      if (take) begin
        dl[i_ch][0] <= i_data;
        s0[0] <= i_data;
        for (int k = 1; k < N_TAPS; k++) begin
          dl[i_ch][k] <= dl[i_ch][k-1];
          s0[k] <= dl[i_ch][k-1];
        end
      end
      for (int k = 0; k < NU; k++) begin
        s1[k] <= PW'(s0[k]) + PW'(s0[N_TAPS-1-k]);
        s2[k] <= MW'(s1[k]) * MW'(active[k]);
      end
      s1_v <= s0_v;
      s1_c <= s0_c;
      s2_v <= s1_v;
      s2_c <= s1_c;
    end
  // swap ignores stalls; a same-edge write lands only in the shadow bank
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      shadow <= '{default: '0};
      active <= '{default: '0};
    end else begin
      if (coef_we) shadow[coef_addr] <= coef_data;
      if (coef_swap) active <= shadow;
    end
  fir_adder_tree #(.N(NU), .W(MW), .CHW(CHW)) u_tree (
    .clk(clk), .reset(reset), .en(adv), .d_valid(s2_v), .d_ch(s2_c), .d(s2),
    .q_valid(t_v), .q_ch(t_c), .q(t_sum)
  );
  assign rr = rnd(64'(t_sum), FRAC);
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      o_valid <= 1'b0;
      o_data <= '0;
      o_ch <= '0;
      o_sat <= 1'b0;
    end else if (adv) begin
      o_valid <= t_v;
      o_ch <= t_c;
      o_data <= DW'(clip(rr, DW));
      o_sat <= t_v & clipped(rr, DW);
    end
endmodule

// File: tb/tb_fir_sym_mc.sv
// tb_fir_sym_mc: directed checks of fir_sym_mc (DW=18, CW=18, 16 taps, 2 channels, FRAC=4)
module tb_fir_sym_mc;
  logic clk = 0, reset = 0, i_valid = 0, i_ready, o_valid, o_ready = 1, o_sat, coef_we = 0, coef_swap = 0;
  logic signed [17:0] i_data = 0, o_data, coef_data = 0;
  logic i_ch = 0, o_ch;
  logic [2:0] coef_addr = 0;
  int n_vec = 0, n_bad = 0;
  logic signed [17:0] qd [$];
  logic qc [$], qs [$];
  int imp [17] = '{1, 2, 3, 4, 5, 6, 7, 8, 8, 7, 6, 5, 4, 3, 2, 1, 0};
  int dbexp [16] = '{1, 2, 3, 4, 5, 105, 106, 107, 107, 106, 105, 104, 103, 102, 101, 100};
  logic signed [17:0] rv [4] = '{18'sd8, 18'sd7, -18'sd8, -18'sd9};
  int rexp [4] = '{1, 0, 0, -1};
  fir_sym_mc #(.DW(18), .CW(18), .N_TAPS(16), .N_CH(2), .FRAC(4)) dut (
    .clk(clk), .reset(reset), .i_valid(i_valid), .i_ready(i_ready), .i_data(i_data), .i_ch(i_ch),
    .o_valid(o_valid), .o_ready(o_ready), .o_data(o_data), .o_ch(o_ch), .o_sat(o_sat),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data), .coef_swap(coef_swap)
  );
  always #5 clk = ~clk;
  always @(negedge clk)
    if (o_valid && o_ready) begin
      qd.push_back(o_data);
      qc.push_back(o_ch);
      qs.push_back(o_sat);
    end
  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic send(input logic ch, input logic signed [17:0] d);
    int n = 0;
    i_valid = 1; i_ch = ch; i_data = d;
    while (!i_ready && n < 50) begin @(posedge clk); #1; n++; end
    if (n >= 50) chk("accept_timeout", 64'(n), 64'(0));
    @(posedge clk); #1;
    i_valid = 0;
  endtask
  task automatic wcoef(input logic [2:0] a, input logic signed [17:0] d);
    coef_we = 1; coef_addr = a; coef_data = d;
    @(posedge clk); #1;
    coef_we = 0;
  endtask
  task automatic pulse_swap();
    coef_swap = 1;
    @(posedge clk); #1;
    coef_swap = 0;
  endtask
  task automatic flush();
    repeat (fir_pkg::lat(16) + 3) begin @(posedge clk); #1; end
  endtask
  task automatic qclr();
    qd.delete(); qc.delete(); qs.delete();
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: summary not reached, observed timeout expected finish");
    $fatal(1);
  end
  initial begin
    #1 reset = 1;
    #1;
    chk("rst_valid", 64'(o_valid), 64'(0));
    chk("rst_data", 64'(o_data), 64'(0));
    chk("rst_ch", 64'(o_ch), 64'(0));
    chk("rst_sat", 64'(o_sat), 64'(0));
    chk("rst_iready", 64'(i_ready), 64'(1));
    @(posedge clk); #1 reset = 0;
    // impulse response and latency
    for (int k = 0; k < 8; k++) wcoef(3'(k), 18'(k + 1));
    pulse_swap();
    qclr();
    send(1'b0, 18'sd16);
    chk("lat_e1", 64'(o_valid), 64'(0));
    for (int e = 2; e <= fir_pkg::lat(16); e++) begin
      @(posedge clk); #1;
      chk(e == fir_pkg::lat(16) ? "lat_hit" : "lat_quiet", 64'(o_valid), 64'(e == fir_pkg::lat(16)));
    end
    for (int i = 0; i < 16; i++) send(1'b0, 18'sd0);
    flush();
    chk("imp_count", 64'(qd.size()), 64'(17));
    for (int i = 0; i < 17; i++) begin
      chk("imp_data", 64'(qd[i]), 64'(imp[i]));
      chk("imp_sat", 64'(qs[i]), 64'(0));
    end
    // round-half-up boundaries
    for (int t = 0; t < 4; t++) begin
      qclr();
      send(1'b0, rv[t]);
      repeat (15) send(1'b0, 18'sd0);
      flush();
      chk("round", 64'(qd[0]), 64'(rexp[t]));
    end
    // channel isolation
    qclr();
    for (int i = 0; i < 17; i++) begin
      send(1'b0, i == 0 ? 18'sd16 : 18'sd0);
      send(1'b1, 18'sd0);
    end
    flush();
    chk("iso_count", 64'(qd.size()), 64'(34));
    for (int i = 0; i < 17; i++) begin
      chk("iso_ch0_data", 64'(qd[2*i]), 64'(imp[i]));
      chk("iso_ch0_ch", 64'(qc[2*i]), 64'(0));
      chk("iso_ch1_data", 64'(qd[2*i+1]), 64'(0));
      chk("iso_ch1_ch", 64'(qc[2*i+1]), 64'(1));
    end
    // backpressure
    qclr();
    for (int i = 0; i < 10; i++) send(1'b0, i == 0 ? 18'sd16 : 18'sd0);
    o_ready = 0; i_valid = 1; i_ch = 0; i_data = 0;
    #1;
    for (int c = 0; c < 5; c++) begin
      chk("bp_iready", 64'(i_ready), 64'(0));
      chk("bp_valid", 64'(o_valid), 64'(1));
      chk("bp_data", 64'(o_data), 64'(4));
      chk("bp_ch", 64'(o_ch), 64'(0));
      @(posedge clk); #1;
    end
    o_ready = 1;
    @(posedge clk); #1;
    i_valid = 0;
    for (int i = 0; i < 6; i++) send(1'b0, 18'sd0);
    flush();
    chk("bp_count", 64'(qd.size()), 64'(17));
    for (int i = 0; i < 17; i++) chk("bp_seq", 64'(qd[i]), 64'(imp[i]));
    // coefficient double buffer with simultaneous write and swap
    for (int k = 0; k < 8; k++) wcoef(3'(k), 18'(100 + k));
    qclr();
    for (int i = 0; i < 16; i++) begin
      if (i == 6) begin coef_swap = 1; coef_we = 1; coef_addr = 0; coef_data = 18'sd999; end
      send(1'b0, i == 0 ? 18'sd16 : 18'sd0);
      coef_swap = 0; coef_we = 0;
    end
    flush();
    chk("db_count", 64'(qd.size()), 64'(16));
    for (int i = 0; i < 16; i++) chk("db_seq", 64'(qd[i]), 64'(dbexp[i]));
    pulse_swap();
    qclr();
    send(1'b1, 18'sd16);
    flush();
    chk("db_late_write", 64'(qd[0]), 64'(999));
    chk("db_late_ch", 64'(qc[0]), 64'(1));
    // saturation in both directions
    for (int k = 0; k < 8; k++) wcoef(3'(k), 18'sd131071);
    pulse_swap();
    qclr();
    for (int i = 0; i < 24; i++) send(1'b0, i < 4 ? 18'sd131071 : 18'h20000);
    flush();
    chk("sat_count", 64'(qd.size()), 64'(24));
    for (int i = 0; i < 4; i++) begin
      chk("sat_pos_data", 64'(qd[i]), 64'(131071));
      chk("sat_pos_flag", 64'(qs[i]), 64'(1));
      chk("sat_neg_data", 64'(qd[20+i]), 64'(-131072));
      chk("sat_neg_flag", 64'(qs[20+i]), 64'(1));
    end
    // reset mid-stream
    for (int i = 0; i < 10; i++) send(1'b0, 18'sd100);
    reset = 1;
    #1;
    chk("mrst_valid", 64'(o_valid), 64'(0));
    chk("mrst_data", 64'(o_data), 64'(0));
    chk("mrst_sat", 64'(o_sat), 64'(0));
    chk("mrst_ch", 64'(o_ch), 64'(0));
    #2 reset = 0;
    qclr();
    for (int i = 0; i < 4; i++) send(1'b0, i == 0 ? 18'sd16 : 18'sd0);
    flush();
    chk("mrst_count", 64'(qd.size()), 64'(4));
    for (int i = 0; i < 4; i++) begin
      chk("mrst_zero_coef", 64'(qd[i]), 64'(0));
      chk("mrst_zero_sat", 64'(qs[i]), 64'(0));
    end
    for (int k = 0; k < 8; k++) wcoef(3'(k), 18'sd1);
    pulse_swap();
    qclr();
    send(1'b1, 18'sd0);
    flush();
    chk("mrst_no_stale", 64'(qd[0]), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
